// File: rtl/ad_regs_mc.sv
// Multi-channel AD register bank on the fx bus: config registers, tear-free status capture,
// sticky flags, sample counters, masked irq. Define AD_REGS_MC_DBG_EN for scratch regs 0x80..0x87.
module ad_regs_mc #(
  parameter int unsigned NCH     = 2,
  parameter logic [7:0]  AVE_RST = 8'h02,
  parameter logic [7:0]  VERSION = 8'h02
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [5:0]        dev_id,
  input  logic              fx_wr,
  input  logic [21:0]       fx_waddr,
  input  logic [7:0]        fx_data,
  input  logic              fx_rd,
  input  logic [21:0]       fx_raddr,
  output logic [7:0]        fx_q,
  input  logic [16*NCH-1:0] stu_data,
  input  logic [NCH-1:0]    stu_vld,
  output logic [7:0]        cfg_ave,
  output logic [NCH-1:0]    cfg_en,
  output logic              irq
);

  logic                  now_wr, now_rd;
  logic [15:0]           waddr, raddr;
  logic [7:0]            rdata;

  logic [7:0]            fx_q_q, fx_q_d;
  logic                  irq_q, irq_d;
  logic [7:0]            cfg_ave_q, cfg_ave_d;
  logic [NCH-1:0]        cfg_en_q, cfg_en_d;
  logic [NCH-1:0]        mask_q, mask_d;
  logic [NCH-1:0][15:0]  hold_q, hold_d;
  logic [NCH-1:0][7:0]   shadow_q, shadow_d;
  logic [NCH-1:0][7:0]   cnt_q, cnt_d;
  logic [NCH-1:0]        new_q, new_d;
  logic [NCH-1:0]        ovr_q, ovr_d;
`ifdef AD_REGS_MC_DBG_EN
  logic [7:0][7:0]       dbg_q, dbg_d;
`endif

  assign now_wr  = fx_wr && (fx_waddr[21:16] == dev_id);
  assign now_rd  = fx_rd && (fx_raddr[21:16] == dev_id);
  assign waddr   = fx_waddr[15:0];
  assign raddr   = fx_raddr[15:0];
  assign fx_q    = fx_q_q;
  assign irq     = irq_q;
  assign cfg_ave = cfg_ave_q;
  assign cfg_en  = cfg_en_q;

  always_comb begin
    rdata = 8'h55;
    case (raddr)
      16'h0000: rdata = {2'b00, dev_id};
      16'h0001: rdata = 8'(NCH);
      16'h0002: rdata = VERSION;
      16'h0020: rdata = cfg_ave_q;
      16'h0021: rdata = 8'(cfg_en_q);
      16'h0022: rdata = 8'(mask_q);
      16'h0030: rdata = 8'(new_q);
      16'h0031: rdata = 8'(ovr_q);
      default: ;
    endcase
    for (int n = 0; n < NCH; n++) begin
      if (raddr == 16'(16'h0010 + 2 * n)) rdata = hold_q[n][7:0];
      if (raddr == 16'(16'h0011 + 2 * n)) rdata = shadow_q[n];
      if (raddr == 16'(16'h0040 + n))     rdata = cnt_q[n];
    end
`ifdef AD_REGS_MC_DBG_EN
    if (raddr[15:3] == 13'h0010) rdata = dbg_q[raddr[2:0]];
`endif
  end

  always_comb begin
    cfg_ave_d = cfg_ave_q;
    cfg_en_d  = cfg_en_q;
    mask_d    = mask_q;
    hold_d    = hold_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    new_d     = new_q;
    ovr_d     = ovr_q;
`ifdef AD_REGS_MC_DBG_EN
    dbg_d     = dbg_q;
    if (now_wr && waddr[15:3] == 13'h0010) dbg_d[waddr[2:0]] = fx_data;
`endif
    if (now_wr) begin
      case (waddr)
        16'h0020: cfg_ave_d = fx_data;
        16'h0021: cfg_en_d  = fx_data[NCH-1:0];
        16'h0022: mask_d    = fx_data[NCH-1:0];
        16'h0030: new_d     = new_q & ~fx_data[NCH-1:0];
        16'h0031: ovr_d     = ovr_q & ~fx_data[NCH-1:0];
        default: ;
      endcase
    end
    // Clears are applied before captures so a coincident capture wins.
    for (int n = 0; n < NCH; n++) begin
      if (now_rd && raddr == 16'(16'h0010 + 2 * n)) begin
        shadow_d[n] = hold_q[n][15:8];
        new_d[n]    = 1'b0;
      end
      if (stu_vld[n] && cfg_en_q[n]) begin
        hold_d[n] = stu_data[16*n +: 16];
        cnt_d[n]  = cnt_q[n] + 8'd1;
        new_d[n]  = 1'b1;
        if (new_q[n]) ovr_d[n] = 1'b1;
      end
    end
    fx_q_d = now_rd ? rdata : 8'h00;
    irq_d  = (|(new_q & mask_q)) | (|ovr_q);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q_q    <= 8'h00;
      irq_q     <= 1'b0;
      cfg_ave_q <= AVE_RST;
      cfg_en_q  <= '1;
      mask_q    <= '0;
      hold_q    <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      new_q     <= '0;
      ovr_q     <= '0;
`ifdef AD_REGS_MC_DBG_EN
      for (int i = 0; i < 8; i++) dbg_q[i] <= 8'h80 + 8'(i);
`endif
    end else begin
      fx_q_q    <= fx_q_d;
      irq_q     <= irq_d;
      cfg_ave_q <= cfg_ave_d;
      cfg_en_q  <= cfg_en_d;
      mask_q    <= mask_d;
      hold_q    <= hold_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      new_q     <= new_d;
      ovr_q     <= ovr_d;
`ifdef AD_REGS_MC_DBG_EN
      dbg_q     <= dbg_d;
`endif
    end
  end

endmodule

// File: tb/tb_ad_regs_mc.sv
// Self-checking bench for ad_regs_mc (NCH=2): directed scenarios, then random traffic
// checked every cycle against a behavioural register-map model.
module tb_ad_regs_mc;
  localparam int NCH = 2;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  dev_id = 6'h05;
  logic        fx_wr = 1'b0, fx_rd = 1'b0;
  logic [21:0] fx_waddr = '0, fx_raddr = '0;
  logic [7:0]  fx_data = '0;
  logic [7:0]  fx_q;
  logic [31:0] stu_data = '0;
  logic [1:0]  stu_vld = '0;
  logic [7:0]  cfg_ave;
  logic [1:0]  cfg_en;
  logic        irq;

  ad_regs_mc #(.NCH(NCH), .AVE_RST(8'h02), .VERSION(8'h02)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .stu_data(stu_data), .stu_vld(stu_vld),
    .cfg_ave(cfg_ave), .cfg_en(cfg_en), .irq(irq)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_err = 0;

  // Behavioural model of the register map
  logic [7:0]  m_ave, m_dbg[8], m_shadow[2], m_cnt[2];
  logic [1:0]  m_en, m_mask, m_new, m_ovr;
  logic [15:0] m_hold[2];
  logic [7:0]  exp_q;
  logic        exp_irq;
  logic [31:0] sd_cur = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic m_reset();
    m_ave = 8'h02; m_en = 2'b11; m_mask = '0; m_new = '0; m_ovr = '0;
    for (int i = 0; i < 2; i++) begin m_hold[i] = '0; m_shadow[i] = '0; m_cnt[i] = '0; end
    for (int i = 0; i < 8; i++) m_dbg[i] = 8'h80 + 8'(i);
    exp_q = '0; exp_irq = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [7:0] v;
    v = 8'h55;
    case (a)
      16'h00: v = {2'b00, dev_id};
      16'h01: v = 8'd2;
      16'h02: v = 8'h02;
      16'h10: v = m_hold[0][7:0];
      16'h11: v = m_shadow[0];
      16'h12: v = m_hold[1][7:0];
      16'h13: v = m_shadow[1];
      16'h20: v = m_ave;
      16'h21: v = {6'b0, m_en};
      16'h22: v = {6'b0, m_mask};
      16'h30: v = {6'b0, m_new};
      16'h31: v = {6'b0, m_ovr};
      16'h40: v = m_cnt[0];
      16'h41: v = m_cnt[1];
      default: ;
    endcase
`ifdef AD_REGS_MC_DBG_EN
    if (a >= 16'h80 && a <= 16'h87) v = m_dbg[a[2:0]];
`endif
    return v;
  endfunction

  function automatic logic [21:0] dv(input logic [15:0] r);
    return {dev_id, r};
  endfunction

  // One clock of stimulus; model advanced, all outputs compared after the edge.
  task automatic cycle(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [21:0] ra, input logic [1:0] vld,
                       input logic [31:0] sd);
    logic selw, selr;
    logic [1:0] en_old, new_old, nn, no;
    fx_wr = wr; fx_waddr = wa; fx_data = wd; fx_rd = rd; fx_raddr = ra;
    stu_vld = vld; stu_data = sd; sd_cur = sd;
    selw = wr && wa[21:16] == dev_id;
    selr = rd && ra[21:16] == dev_id;
    exp_q = selr ? m_read(ra[15:0]) : 8'h00;
    exp_irq = ((m_new & m_mask) != 0) || (m_ovr != 0);
    en_old = m_en; new_old = m_new; nn = m_new; no = m_ovr;
    if (selw) begin
      case (wa[15:0])
        16'h20: m_ave = wd;
        16'h21: m_en = wd[1:0];
        16'h22: m_mask = wd[1:0];
        16'h30: nn = nn & ~wd[1:0];
        16'h31: no = no & ~wd[1:0];
        default: ;
      endcase
`ifdef AD_REGS_MC_DBG_EN
      if (wa[15:0] >= 16'h80 && wa[15:0] <= 16'h87) m_dbg[wa[2:0]] = wd;
`endif
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (selr && ra[15:0] == 16'(16'h10 + 2 * ch)) begin
        m_shadow[ch] = m_hold[ch][15:8];
        nn[ch] = 1'b0;
      end
      if (vld[ch] && en_old[ch]) begin
        m_hold[ch] = sd[16*ch +: 16];
        m_cnt[ch] = 8'((int'(m_cnt[ch]) + 1) % 256);
        if (new_old[ch]) no[ch] = 1'b1;
        nn[ch] = 1'b1;
      end
    end
    m_new = nn; m_ovr = no;
    @(posedge clk_sys); #1;
    chk("cyc_fx_q", fx_q, exp_q);
    chk("cyc_irq", {7'b0, irq}, {7'b0, exp_irq});
    chk("cyc_cfg_ave", cfg_ave, m_ave);
    chk("cyc_cfg_en", {6'b0, cfg_en}, {6'b0, m_en});
    fx_wr = 1'b0; fx_rd = 1'b0; stu_vld = '0;
  endtask

  task automatic rd(input logic [15:0] r);
    cycle(1'b0, '0, '0, 1'b1, dv(r), 2'b00, sd_cur);
  endtask
  task automatic wr(input logic [15:0] r, input logic [7:0] d);
    cycle(1'b1, dv(r), d, 1'b0, '0, 2'b00, sd_cur);
  endtask
  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, 2'b00, sd_cur);
  endtask
  task automatic cap(input logic [1:0] v, input logic [31:0] sd);
    cycle(1'b0, '0, '0, 1'b0, '0, v, sd);
  endtask

  logic [15:0] rlist[16] = '{16'h00, 16'h01, 16'h02, 16'h10, 16'h11, 16'h12, 16'h13, 16'h20,
                             16'h21, 16'h22, 16'h30, 16'h31, 16'h40, 16'h41, 16'h50, 16'h81};
  logic [15:0] wlist[6] = '{16'h20, 16'h21, 16'h22, 16'h30, 16'h31, 16'h81};

  initial begin
    m_reset();
    #12;
    chk("rst_fx_q", fx_q, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_cfg_ave", cfg_ave, 8'h02);
    chk("rst_cfg_en", {6'b0, cfg_en}, 8'h03);
    rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // Identity and config readback
    rd(16'h00); chk("t1_id", fx_q, 8'h05);
    rd(16'h01); chk("t1_nch", fx_q, 8'h02);
    rd(16'h20); chk("t1_ave", fx_q, 8'h02);
    rd(16'h21); chk("t1_en", fx_q, 8'h03);
    idle();     chk("t1_idle", fx_q, 8'h00);

    // Device select
    cycle(1'b1, {6'h06, 16'h20}, 8'h10, 1'b0, '0, 2'b00, sd_cur);
    rd(16'h20); chk("t2_ignored", fx_q, 8'h02);
    cycle(1'b0, '0, '0, 1'b1, {6'h06, 16'h20}, 2'b00, sd_cur);
    chk("t2_rd_other_id", fx_q, 8'h00);
    wr(16'h20, 8'h10);
    rd(16'h20); chk("t2_written", fx_q, 8'h10);
    cycle(1'b1, dv(16'h20), 8'h33, 1'b1, dv(16'h20), 2'b00, sd_cur);
    chk("t2_same_cycle_old", fx_q, 8'h10);
    rd(16'h20); chk("t2_new_val", fx_q, 8'h33);

    // Tear-free high byte
    cap(2'b10, 32'hABCD_0000);
    cap(2'b00, 32'h5A5A_0000);
    rd(16'h12); chk("t3_lo", fx_q, 8'hCD);
    cap(2'b10, 32'h1234_0000);
    rd(16'h13); chk("t3_hi_shadow", fx_q, 8'hAB);

    // Sticky flags and irq
    wr(16'h30, 8'h03);
    cap(2'b01, 32'h0000_1111);
    cap(2'b01, 32'h0000_2222);
    idle(); chk("t4_irq_ovr", {7'b0, irq}, 8'h01);
    rd(16'h30); chk("t4_new", fx_q, 8'h01);
    rd(16'h31); chk("t4_ovr", fx_q, 8'h01);
    wr(16'h31, 8'h01);
    rd(16'h31); chk("t4_ovr_clr", fx_q, 8'h00);
    rd(16'h10); chk("t4_lo", fx_q, 8'h22);
    rd(16'h30); chk("t4_new_clr", fx_q, 8'h00);
    idle(); chk("t4_irq_low", {7'b0, irq}, 8'h00);
    wr(16'h22, 8'h01);
    cap(2'b01, 32'h0000_3333);
    idle(); chk("t4_irq_mask", {7'b0, irq}, 8'h01);

    // Asynchronous reset with a read in flight
    fx_rd = 1'b1; fx_raddr = dv(16'h20);
    #2 rst_n = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_mid_fx_q", fx_q, 8'h00);
    chk("rst_mid_ave", cfg_ave, 8'h02);
    chk("rst_mid_irq", {7'b0, irq}, 8'h00);
    fx_rd = 1'b0;
    m_reset();
    @(negedge clk_sys); rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // Counter wrap, disabled channel, set-wins
    for (int i = 0; i < 256; i++) cap(2'b01, 32'(i));
    rd(16'h40); chk("t5_wrap", fx_q, 8'h00);
    wr(16'h21, 8'h00);
    cap(2'b01, 32'h0); cap(2'b01, 32'h0);
    rd(16'h40); chk("t5_disabled", fx_q, 8'h00);
    wr(16'h21, 8'h03);
    wr(16'h30, 8'h01);
    cycle(1'b1, dv(16'h30), 8'h01, 1'b0, '0, 2'b01, 32'h0000_7777);
    rd(16'h30); chk("t5_set_wins", fx_q, 8'h01);

    // Unmapped and scratch
    rd(16'h81);
`ifdef AD_REGS_MC_DBG_EN
    chk("t6_dbg", fx_q, 8'h81);
`else
    chk("t6_dbg", fx_q, 8'h55);
`endif
    rd(16'h50); chk("t6_unmapped", fx_q, 8'h55);
    rd(16'h44); chk("t6_cnt_oob", fx_q, 8'h55);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] wid, rid;
      wid = ($urandom_range(0, 7) == 0) ? (dev_id ^ 6'h01) : dev_id;
      rid = ($urandom_range(0, 7) == 0) ? (dev_id ^ 6'h02) : dev_id;
      cycle($urandom_range(0, 2) == 0, {wid, wlist[$urandom_range(0, 5)]}, 8'($urandom),
            $urandom_range(0, 1) == 1, {rid, rlist[$urandom_range(0, 15)]},
            2'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
